// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI byte-stream command decoder with 8x8 register bank
module spi_reg_bank #(
  parameter logic [7:0] ID_VALUE = 8'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic [7:0] led,
  output logic       reg_wr,
  output logic [2:0] reg_wr_addr,
  output logic       proto_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] regs_q [0:6];
  logic       wr_en;
  logic       proto_err_q, proto_err_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       reg_wr_q;
  logic [2:0] reg_wr_addr_q;
  logic [7:0] rd_data;

  // Next state / address / write strobe; frame_start beats frame_end beats rx_valid
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_en       = 1'b0;
    proto_err_d = proto_err_q;
    if (frame_start) begin
      state_d = S_CMD;
    end else if (frame_end) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: proto_err_d = 1'b1;
        S_CMD: begin
          addr_d  = rx_byte[2:0];
          state_d = rx_byte[7] ? S_WRITE : S_READ;
        end
        S_WRITE: begin
          wr_en  = (addr_q != 3'd7);
          addr_d = addr_q + 3'd1;
        end
        S_READ: addr_d = addr_q + 3'd1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read mux on the upcoming address; r7 is the constant ID
  always_comb begin
    rd_data = ID_VALUE;
    case (addr_d)
      3'd0: rd_data = regs_q[0];
      3'd1: rd_data = regs_q[1];
      3'd2: rd_data = regs_q[2];
      3'd3: rd_data = regs_q[3];
      3'd4: rd_data = regs_q[4];
      3'd5: rd_data = regs_q[5];
      3'd6: rd_data = regs_q[6];
      default: rd_data = ID_VALUE;
    endcase
  end

  // Transmit byte follows the state being entered so it lines up with state_q
  always_comb begin
    tx_byte_d = 8'h00;
    case (state_d)
      S_IDLE:  tx_byte_d = ID_VALUE;
      S_READ:  tx_byte_d = rd_data;
      default: tx_byte_d = 8'h00;
    endcase
  end

  // Control state, sticky error flag and transmit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= 3'd0;
      proto_err_q   <= 1'b0;
      tx_byte_q     <= ID_VALUE;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      proto_err_q <= proto_err_d;
      tx_byte_q   <= tx_byte_d;
      reg_wr_q    <= wr_en;
      if (wr_en) begin
        reg_wr_addr_q <= addr_q;
      end
    end
  end

  // Writable registers r0..r6
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (wr_en && (addr_q == 3'(i))) begin
          regs_q[i] <= rx_byte;
        end
      end
    end
  end

  assign tx_byte     = tx_byte_q;
  assign led         = regs_q[0];
  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign proto_err   = proto_err_q;

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Byte-level command decoder and 8×8-bit register bank that consumes the received-byte stream of the SPI slave front end. It interprets each SSEL-framed transfer as one command byte followed by data bytes. Data bytes are either written into the bank or read back through a transmit byte for MISO. Register 0 drives the board LEDs.

## Interface
- `ID_VALUE`, default 8'h5A: constant returned by read-only register 7.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `frame_start` in 1: one-cycle pulse, SSEL went active.
- `frame_end` in 1: one-cycle pulse, SSEL went inactive.
- `rx_valid` in 1: one-cycle pulse, `rx_byte` holds a complete received byte.
- `rx_byte` in 8: received byte, MSB first as shifted in; valid only with `rx_valid`.
- `tx_byte` out 8: byte to shift out on MISO for the next byte slot; registered.
- `led` out 8: contents of register 0; registered.
- `reg_wr` out 1: one-cycle pulse on every accepted write to registers 0–6.
- `reg_wr_addr` out 3: address of the write flagged by `reg_wr`.
- `proto_err` out 1: sticky flag; set by `rx_valid` outside a frame; cleared only by reset.

## Operation
- Register bank r0..r7:
  - r0..r6 are read/write.
  - r7 is read-only and always equals `ID_VALUE`; writes to it are discarded, with no `reg_wr` pulse.
- Command byte layout:
  - bit7 = 1 for write, 0 for read.
  - bits[2:0] = start address.
  - bits[6:3] are ignored.
- FSM states: IDLE, CMD, WRITE, READ.
  - IDLE: `frame_start` → CMD. `rx_valid` → set `proto_err`, stay in IDLE.
  - CMD: `rx_valid` latches `addr <= rx_byte[2:0]`, then goes to WRITE if bit7 = 1, otherwise READ.
  - WRITE: each `rx_valid` writes `rx_byte` to r[addr] (unless addr = 7), pulses `reg_wr` with `reg_wr_addr = addr`, then sets `addr <= addr + 1` (3-bit, wraps 7→0).
  - READ: each `rx_valid` sets `addr <= addr + 1` (wraps); incoming data is ignored.
  - Any state: `frame_end` → IDLE.
  - Any state: `frame_start` → CMD (restarts the frame).
- `tx_byte` contents:
  - In READ: r[addr], reflecting the current addr.
  - In WRITE and CMD: 8'h00.
  - In IDLE: `ID_VALUE`.
- Simultaneous events:
  - `frame_end` with `rx_valid`: `frame_end` wins; the byte is dropped, with no write and no `proto_err`.
  - `frame_start` with `rx_valid`: `frame_start` wins; the byte is dropped.
  - `frame_start` with `frame_end`: `frame_start` wins.
- A frame holding only a command byte changes no registers.

## Timing
- Reset values, all applied asynchronously:
  - r0..r6 = 0, `led` = 8'h00, `tx_byte` = `ID_VALUE`.
  - `reg_wr` = 0, `reg_wr_addr` = 0, `proto_err` = 0, state = IDLE, addr = 0.
- A write takes effect on the `clk` edge where `rx_valid` is sampled.
  - r[addr], `led` (when addr = 0) and the `reg_wr` pulse are all visible in the cycle after that `rx_valid`.
- `tx_byte` updates one cycle after the `rx_valid` or state change that alters state or addr.
  - Upstream samples `tx_byte` at least 2 cycles after `rx_valid`; this is guaranteed by the SCLK oversampling ratio.
- Exactly one register write per `rx_valid`. No back-pressure.
- Reset asserted mid-frame: everything returns to reset values immediately. Bytes arriving after `rst_n` deasserts are ignored until `frame_start`, and each sets `proto_err`.

## Test plan
- Reset, then idle: `led` = 8'h00, `tx_byte` = 8'h5A, `proto_err` = 0.
- Write burst `frame_start`, 8'h80, 8'h3C, 8'hC3, `frame_end`:
  - Required: r0 = 8'h3C, r1 = 8'hC3, `led` = 8'h3C.
  - `reg_wr` pulses twice, with `reg_wr_addr` 0 then 1.
- Write wrap and read-only register, `frame_start`, 8'h86, 8'h11, 8'h22, 8'h33:
  - Required: r6 = 8'h11, r7 stays 8'h5A, r0 = 8'h33.
  - Exactly two `reg_wr` pulses, with addr 6 then 0.
- Read burst after the above, `frame_start`, 8'h06, then three dummy bytes:
  - Required: `tx_byte` sequence is 8'h11, 8'h5A, 8'h33. Registers are unchanged.
- Protocol error: `rx_valid` with 8'hFF while IDLE:
  - Required: `proto_err` = 1 and stays 1 across later valid frames. No register changes.
- Collisions and reset:
  - `frame_end` coincident with a data `rx_valid` in WRITE: no write occurs.
  - `rst_n` pulled low mid-write-burst: r0..r6 = 0 and `led` = 0 immediately (asynchronous).
